// File: rtl/sdr_key_pkg.sv
// Shared types and constants for the SDR key sequencer: FSM states, the
// per-step read address sequence and the bus idle pattern.
package sdr_key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        CLEAR,
        READ,
        WAIT_BUS,
        DONE
    } state_t;

    typedef struct packed {
        logic       sser;
        logic       ba13;
        logic       ba12;
        logic       br_w;
        logic [3:0] ba_nib;
    } bus_t;

    localparam bus_t BUS_IDLE = '{sser: 1'b1, ba13: 1'b1, ba12: 1'b0, br_w: 1'b1, ba_nib: 4'h0};

    // Entry 0 is the lowest nibble: 2,A,B,9,A,2,B,9 repeated.
    localparam logic [15:0][3:0] KEY_SEQ = 64'h9B2A_9BA2_9B2A_9BA2;

    // Selected window cycle; rd=0 is the device-reset write, rd=1 a key read.
    function automatic bus_t bus_cycle(input logic rd, input logic [3:0] nib);
        bus_t b;
        b.sser   = 1'b0;
        b.ba13   = 1'b0;
        b.ba12   = 1'b1;
        b.br_w   = rd;
        b.ba_nib = nib;
        return b;
    endfunction

endpackage

// File: rtl/sdr_key_sequencer_if.sv
// Signal bundle between the key sequencer and its requesters, the window bus
// and the key device.
interface sdr_key_sequencer_if
    import sdr_key_pkg::*;
#(
    parameter int NBITS = 8
);
    // req is a level held by a requester; gnt is one-hot and held from
    // arbitration until the sequence ends; done pulses one cycle with
    // key_data/err valid, and the requester must drop req before it can be
    // granted again.
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             bus_free;
    logic             sser;
    logic             ba13;
    logic             ba12;
    logic [3:0]       ba_nib;
    logic             br_w;
    logic             sdrd;
    logic [NBITS-1:0] key_data;
    logic             done;
    logic             err;
    logic             busy;
    state_t           state_dbg;
    logic             ptr_dbg;

    modport master (
        input  req, bus_free, sdrd,
        output gnt, sser, ba13, ba12, ba_nib, br_w, key_data, done, err, busy,
        output state_dbg, ptr_dbg
    );

    modport slave (
        output req, bus_free, sdrd,
        input  gnt, sser, ba13, ba12, ba_nib, br_w, key_data, done, err, busy,
        input  state_dbg, ptr_dbg
    );

endinterface

// File: rtl/sdr_key_sequencer_rr_arb2.sv
// Two-way round-robin arbiter with a held grant and a per-requester block that
// keeps a just-served requester out until it has dropped its request.
module sdr_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       lock,
    input  logic       advance,
    output logic       any_req,
    output logic [1:0] gnt,
    output logic       pointer
);

    logic [1:0] blocked;
    logic [1:0] eligible;
    logic [1:0] pick;

    assign eligible = req & ~blocked;
    assign any_req  = |eligible;

    always_comb begin
        pick = 2'b00;
        if (!pointer) begin
            if (eligible[0])      pick = 2'b01;
            else if (eligible[1]) pick = 2'b10;
        end else begin
            if (eligible[1])      pick = 2'b10;
            else if (eligible[0]) pick = 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt     <= 2'b00;
            pointer <= 1'b0;
            blocked <= 2'b00;
        end else begin
            if (lock) begin
                gnt <= pick;
            end else if (advance) begin
                gnt     <= 2'b00;
                pointer <= ~gnt[1];
            end
            // Served side is blocked at sequence end; any cycle with req low unblocks.
            for (int i = 0; i < 2; i++) begin
                if (advance && gnt[i]) blocked[i] <= 1'b1;
                else if (!req[i])      blocked[i] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdr_key_sequencer.sv
// Serial key reader: arbitrates two requesters, resets the key device with a
// write cycle, then clocks NBITS key bits out of it MSB first, with retries on bus loss.
module sdr_key_sequencer
    import sdr_key_pkg::*;
#(
    parameter int NBITS     = 8,
    parameter int MAX_RETRY = 3
) (
    input logic                clk,
    input logic                rst,
    sdr_key_sequencer_if.master io
);

    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    localparam logic [3:0]    LAST_STEP   = 4'(NBITS - 1);

    state_t           state;
    logic [3:0]       step;
    logic [RW-1:0]    retry;
    logic [NBITS-1:0] key_q;
    logic             err_q;
    logic             any_req;
    logic             lock;
    logic             advance;
    logic [1:0]       gnt;
    logic             pointer;
    bus_t             bus;

    assign lock    = (state == ARB) && any_req && io.bus_free;
    assign advance = (state == DONE);

    sdr_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (io.req),
        .lock    (lock),
        .advance (advance),
        .any_req (any_req),
        .gnt     (gnt),
        .pointer (pointer)
    );

    // Losing the bus drops the select in the same cycle, before the FSM reacts.
    always_comb begin
        bus = BUS_IDLE;
        if (io.bus_free) begin
            if (state == CLEAR)     bus = bus_cycle(1'b0, 4'h0);
            else if (state == READ) bus = bus_cycle(1'b1, KEY_SEQ[step]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            step  <= 4'd0;
            retry <= '0;
            key_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) state <= ARB;
                end
                ARB: begin
                    retry <= '0;
                    err_q <= 1'b0;
                    if (!any_req)        state <= IDLE;
                    else if (io.bus_free) state <= CLEAR;
                end
                CLEAR: begin
                    step  <= 4'd0;
                    key_q <= '0;
                    if (!io.bus_free) begin
                        state <= WAIT_BUS;
                        retry <= retry + RW'(1);
                    end else begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (!io.bus_free) begin
                        state <= WAIT_BUS;
                        retry <= retry + RW'(1);
                    end else begin
                        key_q <= (key_q << 1) | NBITS'(io.sdrd);
                        step  <= step + 4'd1;
                        if (step == LAST_STEP) state <= DONE;
                    end
                end
                WAIT_BUS: begin
                    if (retry > RETRY_LIMIT) begin
                        state <= DONE;
                        err_q <= 1'b1;
                        key_q <= '0;
                    end else if (io.bus_free) begin
                        state <= CLEAR;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    err_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.sser      = bus.sser;
    assign io.ba13      = bus.ba13;
    assign io.ba12      = bus.ba12;
    assign io.br_w      = bus.br_w;
    assign io.ba_nib    = bus.ba_nib;
    assign io.gnt       = gnt;
    assign io.key_data  = key_q;
    assign io.done      = (state == DONE);
    assign io.err       = err_q;
    assign io.busy      = (state != IDLE);
    assign io.state_dbg = state;
    assign io.ptr_dbg   = pointer;

endmodule

// File: tb/tb_sdr_key_sequencer.sv
// Directed bench for sdr_key_sequencer: a serial key device model, a result
// scoreboard popped on every done pulse, and per-cycle bus checks.
module tb_sdr_key_sequencer;
    import sdr_key_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [10:0] exp_q[$];
    logic [7:0]  dev_key;
    int          dev_idx;
    logic [3:0]  exp_nib [8] = '{4'h2, 4'hA, 4'hB, 4'h9, 4'hA, 4'h2, 4'hB, 4'h9};

    sdr_key_sequencer_if #(.NBITS(8)) sif ();

    sdr_key_sequencer #(.NBITS(8), .MAX_RETRY(3)) dut (
        .clk (clk),
        .rst (rst),
        .io  (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key device: a deselected or write cycle restarts it at the MSB.
    always @(posedge clk or posedge rst) begin
        if (rst)                        dev_idx <= 0;
        else if (sif.sser || !sif.br_w) dev_idx <= 0;
        else                            dev_idx <= dev_idx + 1;
    end

    assign sif.sdrd = (!sif.sser && sif.br_w && dev_idx < 8) ? dev_key[3'(7 - dev_idx)] : 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name, input int waited);
        n_checks++;
        n_errors++;
        $display("FAIL %s: waited %0d cycles without the event", name, waited);
    endtask

    // Monitor: result scoreboard plus bus shape checks each cycle.
    always @(negedge clk) begin
        if (!rst) begin
            check("gnt_onehot", 32'(sif.gnt == 2'b11), 32'd0);
            if (!sif.sser && sif.br_w) begin
                check("read_nib", 32'(sif.ba_nib), 32'(exp_nib[dev_idx[2:0]]));
                check("read_addr", 32'({sif.ba13, sif.ba12}), 32'b01);
            end
            if (sif.done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got done=1 gnt=%b key=%h, expected no pending result",
                             sif.gnt, sif.key_data);
                end else begin
                    check("done_result", 32'({sif.gnt, sif.err, sif.key_data}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // sel: 0 = done pulse, 1 = read cycle, 2 = any grant
    task automatic wait_for(input int sel, input int max, output int cycles);
        bit hit;
        hit    = 1'b0;
        cycles = 0;
        while (!hit && cycles < max) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            case (sel)
                0:       hit = sif.done;
                1:       hit = !sif.sser && sif.br_w;
                default: hit = (sif.gnt != 2'b00);
            endcase
        end
        if (!hit) timeout($sformatf("wait_sel%0d", sel), cycles);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        n_checks     = 0;
        n_errors     = 0;
        dev_key      = 8'h00;
        rst          = 1'b1;
        sif.req      = 2'b00;
        sif.bus_free = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_sser", 32'(sif.sser), 32'd1);
        check("rst_ba13", 32'(sif.ba13), 32'd1);
        check("rst_ba12", 32'(sif.ba12), 32'd0);
        check("rst_br_w", 32'(sif.br_w), 32'd1);
        check("rst_nib", 32'(sif.ba_nib), 32'd0);
        check("rst_gnt", 32'(sif.gnt), 32'd0);
        check("rst_done_err_busy", 32'({sif.done, sif.err, sif.busy}), 32'd0);
        check("rst_key", 32'(sif.key_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);

        // Single request, key A5, latency and ARB/CLEAR shape
        dev_key = 8'hA5;
        exp_q.push_back({2'b01, 1'b0, 8'hA5});
        sif.req = 2'b01;
        @(negedge clk);
        check("arb_gnt", 32'(sif.gnt), 32'd0);
        check("arb_busy", 32'(sif.busy), 32'd1);
        check("arb_state", 32'(sif.state_dbg), 32'(ARB));
        @(negedge clk);
        check("clear_bus", 32'({sif.sser, sif.ba13, sif.ba12, sif.br_w}), 32'b0010);
        check("clear_gnt", 32'(sif.gnt), 32'b01);
        wait_for(0, 30, cyc);
        check("done_latency", 32'(2 + cyc), 32'd11);
        sif.req = 2'b00;
        idle_cycles(2);
        check("idle_after_done", 32'({sif.busy, sif.gnt}), 32'd0);

        // Simultaneous requests from reset: 0 then 1
        rst     = 1'b1;
        sif.req = 2'b11;
        dev_key = 8'h3C;
        idle_cycles(2);
        exp_q.push_back({2'b01, 1'b0, 8'h3C});
        exp_q.push_back({2'b10, 1'b0, 8'h3C});
        rst = 1'b0;
        wait_for(0, 30, cyc);
        wait_for(0, 30, cyc);
        sif.req = 2'b00;
        idle_cycles(3);

        // Bus loss at READ step 4, then a clean restart
        dev_key = 8'h96;
        exp_q.push_back({2'b01, 1'b0, 8'h96});
        sif.req = 2'b01;
        wait_for(1, 10, cyc);
        idle_cycles(4);
        sif.bus_free = 1'b0;
        #1;
        check("loss_bus_idle", 32'({sif.sser, sif.ba13, sif.ba12, sif.br_w, sif.ba_nib}), 32'b1101_0000);
        @(negedge clk);
        check("loss_state", 32'(sif.state_dbg), 32'(WAIT_BUS));
        check("loss_busy", 32'(sif.busy), 32'd1);
        @(negedge clk);
        sif.bus_free = 1'b1;
        wait_for(0, 30, cyc);
        sif.req = 2'b00;
        idle_cycles(3);

        // Retry exhaustion: four losses give err with zero key
        dev_key = 8'hFF;
        exp_q.push_back({2'b10, 1'b1, 8'h00});
        sif.req = 2'b10;
        for (int k = 0; k < 4; k++) begin
            wait_for(1, 10, cyc);
            sif.bus_free = 1'b0;
            @(negedge clk);
            sif.bus_free = 1'b1;
        end
        wait_for(0, 10, cyc);
        check("exhaust_latency", 32'(cyc), 32'd1);
        sif.req = 2'b00;
        idle_cycles(3);

        // Async reset at READ step 3: immediate reset values, no done
        dev_key = 8'h81;
        sif.req = 2'b01;
        wait_for(1, 10, cyc);
        idle_cycles(3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_bus", 32'({sif.sser, sif.ba13, sif.ba12, sif.br_w, sif.ba_nib}), 32'b1101_0000);
        check("arst_ctl", 32'({sif.gnt, sif.done, sif.err, sif.busy}), 32'd0);
        check("arst_key", 32'(sif.key_data), 32'd0);
        sif.req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(15);

        // Requester drops right after grant
        dev_key = 8'h5A;
        exp_q.push_back({2'b10, 1'b0, 8'h5A});
        sif.req = 2'b10;
        wait_for(2, 10, cyc);
        check("drop_gnt", 32'(sif.gnt), 32'b10);
        sif.req = 2'b00;
        wait_for(0, 30, cyc);
        idle_cycles(2);

        // Held request is not re-granted until it drops
        dev_key = 8'hC3;
        exp_q.push_back({2'b01, 1'b0, 8'hC3});
        sif.req = 2'b01;
        wait_for(0, 30, cyc);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_no_regrant", 32'({sif.busy, sif.gnt}), 32'd0);
        end
        sif.req = 2'b00;
        @(negedge clk);
        dev_key = 8'h3E;
        exp_q.push_back({2'b01, 1'b0, 8'h3E});
        sif.req = 2'b01;
        wait_for(0, 30, cyc);
        sif.req = 2'b00;
        idle_cycles(3);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sdr_key_sequencer.md
SDR_KEY_SEQUENCER -- requirements
Module: sdr_key_sequencer

Interface
REQ-001 Parameter NBITS, default 8: number of serial key bits collected per sequence (range 1..16).
REQ-002 Parameter MAX_RETRY, default 3: number of restarts allowed after a bus loss before the block reports an error.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port req[1:0], input, 2: per-requester level request for one key sequence.
REQ-006 Port gnt[1:0], output, 2: one-hot grant; held from ARB exit until DONE.
REQ-007 Port bus_free, input, 1: high when the controller may own the security-window bus.
REQ-008 Port sser, output, 1: active-low select of the key device.
REQ-009 Ports ba13 and ba12, outputs, 1 each: window address bits.
REQ-010 Port ba_nib[3:0], output, 4: address bits BA7..BA4.
REQ-011 Port br_w, output, 1: high = read cycle, low = write cycle.
REQ-012 Port sdrd, input, 1: serial key data bit from the device, pulled up on the board.
REQ-013 Port key_data[NBITS-1:0], output, NBITS: collected key, MSB first.
REQ-014 Port done, output, 1: one-cycle pulse marking sequence end; key_data and err are valid in that cycle.
REQ-015 Port err, output, 1: set with done when retries are exhausted.
REQ-016 Port busy, output, 1: high in every state except IDLE.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, ARB, CLEAR, READ, WAIT_BUS, DONE.
REQ-018 Bus idle values (IDLE, ARB, WAIT_BUS, DONE) SHALL be: sser=1, ba13=1, ba12=0, br_w=1, ba_nib=0.
REQ-019 From IDLE, when any req bit is high, the FSM SHALL enter ARB the next cycle.
REQ-020 ARB SHALL choose a requester by round-robin: the pointer starts at 0 after reset and, after each DONE, moves to the requester that was not just served.
REQ-021 ARB SHALL assert gnt for the chosen requester and move to CLEAR when bus_free=1; otherwise it SHALL stay in ARB.
REQ-022 CLEAR SHALL last 1 cycle with sser=0, ba13=0, ba12=1, br_w=0; this write cycle returns the device to its start state.
REQ-023 CLEAR SHALL zero the step counter and key_data.
REQ-024 READ SHALL last exactly NBITS consecutive cycles with sser=0, ba13=0, ba12=1, br_w=1, and ba_nib=KEY_SEQ[step].
REQ-025 On each READ clock edge, key_data SHALL shift left with sdrd entering at the LSB, and step SHALL increment.
REQ-026 READ cycles SHALL be gap-free, because any deselected cycle resets the device.
REQ-027 After the READ cycle with step=NBITS-1, the FSM SHALL enter DONE.
REQ-028 DONE SHALL last 1 cycle: done=1, gnt cleared at its exit, then IDLE.
REQ-029 If bus_free=0 during CLEAR or READ, the bus SHALL go to idle values in the same cycle (combinational gating) and the FSM SHALL enter WAIT_BUS.
REQ-030 WAIT_BUS SHALL increment the retry counter once on entry.
REQ-031 From WAIT_BUS, when bus_free=1 and retries ≤ MAX_RETRY, the FSM SHALL enter CLEAR; when retries > MAX_RETRY, it SHALL enter DONE with err=1 and key_data=0.
REQ-032 The retry counter SHALL reset to 0 in ARB.
REQ-033 A req drop after grant SHALL NOT abort the sequence; done still pulses.
REQ-034 A requester SHALL NOT be re-granted until its req has been low for at least one cycle after done; a req held high through done is ignored until it drops.

Reset
REQ-035 When rst is asserted, the block SHALL immediately set: state IDLE, sser=1, bus outputs to idle values, gnt=0, done=0, err=0, busy=0, key_data=0, pointer=0, retry=0, step=0.
REQ-036 Reset mid-sequence SHALL abandon the sequence with no done pulse.

Structure
REQ-037 Package sdr_key_pkg SHALL hold the state enum, the KEY_SEQ constant (16 x 4-bit, default entries 2,A,B,9,A,2,B,9,...) and the bus idle constants.
REQ-038 The round-robin arbiter SHALL be a sub-module, sdr_rr_arb2 (req, advance, gnt, pointer).

Verification
REQ-039 Single request: req=01, bus_free=1, device model returns A5 -> gnt=01, 1 CLEAR cycle, 8 READ cycles with correct nibbles, done at cycle 11 after req, key_data=0xA5, err=0.
REQ-040 Simultaneous requests: req=11 from reset -> requester 0 served first, requester 1 second, gnt never 11.
REQ-041 Bus loss: bus_free drops at READ step 4 -> sser=1 in that cycle, WAIT_BUS, then on restore a fresh CLEAR and 8 READs; result correct.
REQ-042 Retry exhaustion: bus_free toggled low in every READ, 4 times -> done with err=1 and key_data=0.
REQ-043 Async reset: rst pulsed during READ step 3 -> all outputs at reset values before the next clk edge, no done pulse.
REQ-044 Requester drop: req dropped right after grant -> sequence completes and done pulses.
